// File: rtl/pong_game_controller.sv
// Pong rally sequencer: holds the ball in reset between points, gates
// per-frame ball steps during play, detects goals and keeps both scores.
module pong_game_controller #(
    parameter int unsigned LEFT_GOAL_X  = 15,
    parameter int unsigned RIGHT_GOAL_X = 225,
    parameter int unsigned SERVE_DELAY  = 60,
    parameter int unsigned WIN_SCORE    = 7
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frameTick,
    input  logic       startButton,
    input  logic [7:0] ballXValue,
    input  logic       ballDirection,
    output logic       ballReset,
    output logic       ballStep,
    output logic [3:0] leftScore,
    output logic [3:0] rightScore,
    output logic       lastScorer,
    output logic       gameOver,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SERVE_WAIT = 3'd1,
        PLAY       = 3'd2,
        POINT      = 3'd3,
        GAME_OVER  = 3'd4
    } state_t;

    localparam logic [7:0] LEFT_X     = 8'(LEFT_GOAL_X);
    localparam logic [7:0] RIGHT_X    = 8'(RIGHT_GOAL_X);
    localparam logic [7:0] SERVE_LAST = 8'(SERVE_DELAY - 1);
    localparam logic [3:0] WIN        = 4'(WIN_SCORE);

    state_t     state_q, state_d;
    logic [7:0] serve_count_q, serve_count_d;
    logic [3:0] left_score_q, left_score_d;
    logic [3:0] right_score_q, right_score_d;
    logic       last_scorer_q, last_scorer_d;
    logic       start_prev_q;
    logic       start_armed_q;

    logic       start_press;
    logic       left_goal;
    logic       right_goal;
    logic       goal_tick;

    // A button held through reset stays unarmed until it is seen low once,
    // so it cannot masquerade as a fresh press when reset releases.
    assign start_press = startButton & ~start_prev_q & start_armed_q;

    assign right_goal = ~ballDirection & (ballXValue <= LEFT_X);
    assign left_goal  =  ballDirection & (ballXValue >= RIGHT_X);
    assign goal_tick  = frameTick & (state_q == PLAY) & (left_goal | right_goal);

    // Button edge detector and arming flag.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            start_prev_q  <= 1'b0;
            start_armed_q <= 1'b0;
        end else begin
            start_prev_q  <= startButton;
            start_armed_q <= start_armed_q | ~startButton;
        end
    end

    // Rally state, serve counter and score registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            serve_count_q <= 8'd0;
            left_score_q  <= 4'd0;
            right_score_q <= 4'd0;
            last_scorer_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            serve_count_q <= serve_count_d;
            left_score_q  <= left_score_d;
            right_score_q <= right_score_d;
            last_scorer_q <= last_scorer_d;
        end
    end

    // Next-state, serve counting, goal latching and score update.
    // NOTE: every value written here is defaulted first so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        serve_count_d = serve_count_q;
        left_score_d  = left_score_q;
        right_score_d = right_score_q;
        last_scorer_d = last_scorer_q;

        case (state_q)
            IDLE: begin
                if (start_press) begin
                    left_score_d  = 4'd0;
                    right_score_d = 4'd0;
                    serve_count_d = 8'd0;
                    state_d       = SERVE_WAIT;
                end
            end

            SERVE_WAIT: begin
                if (frameTick) begin
                    if (serve_count_q == SERVE_LAST) begin
                        serve_count_d = 8'd0;
                        state_d       = PLAY;
                    end else begin
                        serve_count_d = serve_count_q + 8'd1;
                    end
                end
            end

            PLAY: begin
                if (goal_tick) begin
                    last_scorer_d = left_goal;
                    state_d       = POINT;
                end
            end

            POINT: begin
                // Ticks landing here are deliberately ignored.
                if (last_scorer_q) begin
                    if (left_score_q < WIN) left_score_d = left_score_q + 4'd1;
                end else begin
                    if (right_score_q < WIN) right_score_d = right_score_q + 4'd1;
                end
                if ((last_scorer_q && left_score_d == WIN) ||
                    (!last_scorer_q && right_score_d == WIN)) begin
                    state_d = GAME_OVER;
                end else begin
                    serve_count_d = 8'd0;
                    state_d       = SERVE_WAIT;
                end
            end

            GAME_OVER: begin
                if (start_press) begin
                    left_score_d  = 4'd0;
                    right_score_d = 4'd0;
                    serve_count_d = 8'd0;
                    state_d       = SERVE_WAIT;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign ballReset  = (state_q != PLAY);
    assign gameOver   = (state_q == GAME_OVER);
    assign ballStep   = frameTick & (state_q == PLAY) & ~goal_tick;
    assign leftScore  = left_score_q;
    assign rightScore = right_score_q;
    assign lastScorer = last_scorer_q;
    assign state      = state_q;

endmodule

// File: tb/tb_pong_game_controller.sv
// Directed bench for pong_game_controller with SERVE_DELAY=3, WIN_SCORE=2.
module tb_pong_game_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic       frameTick;
    logic       startButton;
    logic [7:0] ballXValue;
    logic       ballDirection;
    logic       ballReset;
    logic       ballStep;
    logic [3:0] leftScore;
    logic [3:0] rightScore;
    logic       lastScorer;
    logic       gameOver;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    pong_game_controller #(
        .LEFT_GOAL_X (15),
        .RIGHT_GOAL_X(225),
        .SERVE_DELAY (3),
        .WIN_SCORE   (2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .frameTick    (frameTick),
        .startButton  (startButton),
        .ballXValue   (ballXValue),
        .ballDirection(ballDirection),
        .ballReset    (ballReset),
        .ballStep     (ballStep),
        .leftScore    (leftScore),
        .rightScore   (rightScore),
        .lastScorer   (lastScorer),
        .gameOver     (gameOver),
        .state        (state)
    );

    always #5 clock = ~clock;

    // Advance n clocks; inputs change and outputs are sampled 1 after the edge.
    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // One-cycle frame tick; returns ballStep as seen before the edge.
    task automatic tick(output logic step_seen);
        frameTick = 1'b1;
        #1 step_seen = ballStep;
        @(posedge clock);
        #1;
        frameTick = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; startButton = 1'b1; frameTick = 1'b0;
        ballXValue = 8'd100; ballDirection = 1'b1;
        idle_cycles(3);
        reset = 1'b0;
        idle_cycles(3);
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_held_state got=%0d exp=0", state); end
        checks++; if (ballReset !== 1'b1) begin errors++; $display("FAIL reset_ballReset got=%b exp=1", ballReset); end
        checks++; if (ballStep !== 1'b0 || gameOver !== 1'b0) begin errors++; $display("FAIL reset_step_go got=%b%b exp=00", ballStep, gameOver); end
        checks++; if (leftScore !== 4'd0 || rightScore !== 4'd0 || lastScorer !== 1'b0) begin
            errors++; $display("FAIL reset_scores got=%0d/%0d/%b exp=0/0/0", leftScore, rightScore, lastScorer); end
        startButton = 1'b0;
        idle_cycles(1);
        startButton = 1'b1;
        idle_cycles(1);
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL press_to_serve got=%0d exp=1", state); end
        startButton = 1'b0;
    endtask

    task automatic test_serve;
        logic s;
        tick(s);
        checks++; if (s !== 1'b0 || state !== 3'd1) begin errors++; $display("FAIL serve_tick1 step=%b state=%0d exp=0/1", s, state); end
        idle_cycles(2);
        tick(s);
        checks++; if (s !== 1'b0 || state !== 3'd1) begin errors++; $display("FAIL serve_tick2 step=%b state=%0d exp=0/1", s, state); end
        idle_cycles(1);
        tick(s);
        checks++; if (s !== 1'b0 || state !== 3'd2) begin errors++; $display("FAIL serve_tick3 step=%b state=%0d exp=0/2", s, state); end
        checks++; if (ballReset !== 1'b0) begin errors++; $display("FAIL serve_ballReset got=%b exp=0", ballReset); end
        idle_cycles(1);
        tick(s);
        checks++; if (s !== 1'b1 || state !== 3'd2) begin errors++; $display("FAIL first_step step=%b state=%0d exp=1/2", s, state); end
    endtask

    task automatic test_play_no_goal;
        logic s;
        ballDirection = 1'b1; ballXValue = 8'd15;
        tick(s);
        checks++; if (s !== 1'b1 || state !== 3'd2) begin errors++; $display("FAIL right_at_15 step=%b state=%0d exp=1/2", s, state); end
        ballDirection = 1'b0; ballXValue = 8'd16;
        tick(s);
        checks++; if (s !== 1'b1 || state !== 3'd2) begin errors++; $display("FAIL left_at_16 step=%b state=%0d exp=1/2", s, state); end
        ballDirection = 1'b1; ballXValue = 8'd224;
        tick(s);
        checks++; if (s !== 1'b1 || state !== 3'd2) begin errors++; $display("FAIL right_at_224 step=%b state=%0d exp=1/2", s, state); end
        startButton = 1'b1;
        idle_cycles(1);
        startButton = 1'b0;
        idle_cycles(1);
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL press_in_play got=%0d exp=2", state); end
    endtask

    task automatic test_right_goal;
        logic s;
        ballDirection = 1'b0; ballXValue = 8'd15;
        tick(s);
        checks++; if (s !== 1'b0 || state !== 3'd3) begin errors++; $display("FAIL rgoal_tick step=%b state=%0d exp=0/3", s, state); end
        checks++; if (ballReset !== 1'b1 || rightScore !== 4'd0) begin errors++; $display("FAIL rgoal_point rst=%b rs=%0d exp=1/0", ballReset, rightScore); end
        frameTick = 1'b1;  // lands in POINT and must be dropped
        idle_cycles(1);
        frameTick = 1'b0;
        checks++; if (state !== 3'd1 || rightScore !== 4'd1 || leftScore !== 4'd0 || lastScorer !== 1'b0) begin
            errors++; $display("FAIL rgoal_score state=%0d ls=%0d rs=%0d last=%b exp=1/0/1/0", state, leftScore, rightScore, lastScorer); end
        ballXValue = 8'd100;
        tick(s); tick(s);
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL point_tick_dropped got=%0d exp=1", state); end
        tick(s);
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL reserve_play got=%0d exp=2", state); end
    endtask

    task automatic test_left_goal_and_win;
        logic s;
        ballDirection = 1'b1; ballXValue = 8'd225;
        tick(s);
        checks++; if (s !== 1'b0 || state !== 3'd3) begin errors++; $display("FAIL lgoal_tick step=%b state=%0d exp=0/3", s, state); end
        idle_cycles(1);
        checks++; if (state !== 3'd1 || leftScore !== 4'd1 || rightScore !== 4'd1 || lastScorer !== 1'b1) begin
            errors++; $display("FAIL lgoal_score state=%0d ls=%0d rs=%0d last=%b exp=1/1/1/1", state, leftScore, rightScore, lastScorer); end
        ballXValue = 8'd100;
        tick(s); tick(s); tick(s);
        ballXValue = 8'd240;
        tick(s);
        idle_cycles(1);
        checks++; if (state !== 3'd4 || leftScore !== 4'd2 || gameOver !== 1'b1 || ballReset !== 1'b1) begin
            errors++; $display("FAIL win state=%0d ls=%0d go=%b rst=%b exp=4/2/1/1", state, leftScore, gameOver, ballReset); end
        tick(s); idle_cycles(2);
        checks++; if (state !== 3'd4 || leftScore !== 4'd2 || rightScore !== 4'd1) begin
            errors++; $display("FAIL game_over_hold state=%0d ls=%0d rs=%0d exp=4/2/1", state, leftScore, rightScore); end
        startButton = 1'b1;
        idle_cycles(1);
        startButton = 1'b0;
        checks++; if (state !== 3'd1 || leftScore !== 4'd0 || rightScore !== 4'd0 || gameOver !== 1'b0) begin
            errors++; $display("FAIL restart state=%0d ls=%0d rs=%0d go=%b exp=1/0/0/0", state, leftScore, rightScore, gameOver); end
    endtask

    task automatic test_async_reset;
        logic s;
        ballXValue = 8'd100;
        tick(s); tick(s); tick(s);
        ballDirection = 1'b0; ballXValue = 8'd10;
        tick(s);
        idle_cycles(1);
        ballXValue = 8'd100;
        tick(s); tick(s); tick(s);
        checks++; if (state !== 3'd2 || rightScore !== 4'd1) begin errors++; $display("FAIL pre_reset state=%0d rs=%0d exp=2/1", state, rightScore); end
        #2 reset = 1'b1;
        #1;
        checks++; if (state !== 3'd0 || ballReset !== 1'b1) begin errors++; $display("FAIL async_reset state=%0d rst=%b exp=0/1", state, ballReset); end
        checks++; if (rightScore !== 4'd0 || leftScore !== 4'd0 || gameOver !== 1'b0) begin
            errors++; $display("FAIL async_reset_scores ls=%0d rs=%0d go=%b exp=0/0/0", leftScore, rightScore, gameOver); end
        idle_cycles(1);
        reset = 1'b0;
        idle_cycles(2);
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL post_reset_idle got=%0d exp=0", state); end
    endtask

    initial begin
        test_reset();
        test_serve();
        test_play_no_goal();
        test_right_goal();
        test_left_goal_and_win();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
